port_pair_sched: RTL and testbench

//  Round-robin scheduler that shares one 2-lane unpacked port (d[2] of 32-bit words) between

---
 rtl/port_pair_sched_pkg.sv | 27 ++
 rtl/port_pair_sched_rr_arbiter.sv | 43 ++++
 rtl/port_pair_sched.sv | 148 ++++++++++++++
 tb/tb_port_pair_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_pair_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : port_pair_pkg
// Purpose  : Shared lane types, FSM states and lane-mask constants for the
//            two-lane pair scheduler.
// Revision : 1.0  initial release
// ============================================================================
package port_pair_pkg;

    localparam int LANES  = 2;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t lane_arr_t [LANES];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2,
        OUT   = 2'd3
    } state_e;

    localparam logic [LANES-1:0] MASK_FULL = 2'b11;
    localparam logic [LANES-1:0] MASK_HALF = 2'b01;

endpackage
`default_nettype wire

// File: rtl/port_pair_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first asserted request at or
//            after ptr (wrapping), returned one-hot and as an index.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            found
);

    int            w_pos;
    logic [IW-1:0] w_sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        w_pos = 0;
        w_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            w_sel = IW'(w_pos);
            if (!found && req[w_sel]) begin
                found        = 1'b1;
                grant[w_sel] = 1'b1;
                idx          = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/port_pair_sched.sv
`default_nettype none
// ============================================================================
// Module   : port_pair_sched
// Purpose  : Round-robin scheduler packing word-serial requester traffic into
//            registered two-lane pairs with a valid/ready output handshake.
// Revision : 1.0  initial release
// ============================================================================
module port_pair_sched
    import port_pair_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        out_d [LANES],
    output logic [LANES-1:0]        out_mask,
    output logic [$clog2(NREQ)-1:0] out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int            IW         = $clog2(NREQ);
    localparam int            CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] C_LAST_IDX = IW'(NREQ - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [NREQ-1:0]   r_grant_oh;
    logic [IW-1:0]     r_grant_idx;
    logic [IW-1:0]     r_rr_ptr;
    logic [WIDTH-1:0]  r_lane0;
    logic [WIDTH-1:0]  r_lane1;
    logic [LANES-1:0]  r_mask;
    logic [CW-1:0]     r_cnt;

    logic [NREQ-1:0]   w_arb_grant;
    logic [IW-1:0]     w_arb_idx;
    logic              w_arb_found;
    logic              w_busy;
    logic              w_accept;
    logic [WIDTH-1:0]  w_word;
    logic              w_last;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_arb_grant),
        .idx   (w_arb_idx),
        .found (w_arb_found)
    );

    // Only the granted requester is ever offered ready, and only while collecting.
    assign w_busy    = (r_state == LANE0) || (r_state == LANE1);
    assign req_ready = w_busy ? (r_grant_oh & req_valid) : '0;
    assign w_accept  = |req_ready;
    assign w_word    = req_data[int'(r_grant_idx) * WIDTH +: WIDTH];
    assign w_last    = req_last[r_grant_idx];

    assign out_d[0]  = r_lane0;
    assign out_d[1]  = r_lane1;
    assign out_mask  = r_mask;
    assign out_src   = r_grant_idx;
    assign out_valid = (r_state == OUT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt = LANE0;
                end
            end
            LANE0: begin
                if (w_accept) begin
                    w_state_nxt = w_last ? OUT : LANE1;
                end
            end
            LANE1: begin
                if (w_accept || (r_cnt == C_CNT_LAST)) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant_oh  <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_lane0     <= '0;
            r_lane1     <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_arb_found) begin
                        r_grant_oh  <= w_arb_grant;
                        r_grant_idx <= w_arb_idx;
                    end
                end
                LANE0: begin
                    if (w_accept) begin
                        r_lane0 <= w_word;
                        r_lane1 <= '0;
                        r_mask  <= MASK_HALF;
                        r_cnt   <= '0;
                    end
                end
                LANE1: begin
                    // Counter tops out at TIMEOUT because reaching it leaves LANE1.
                    if (w_accept) begin
                        r_lane1 <= w_word;
                        r_mask  <= MASK_FULL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_rr_ptr <= (r_grant_idx == C_LAST_IDX) ? '0 : r_grant_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_port_pair_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_pair_sched
// Purpose  : Randomized and directed self-checking bench for port_pair_sched
//            against a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_port_pair_sched;
    import port_pair_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 15;
    localparam int QD  = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_last;
    logic [N*32-1:0]  req_data;
    logic [N-1:0]     req_ready;
    lane_arr_t        out_d;
    logic [1:0]       out_mask;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready;

    port_pair_sched #(.NREQ(N), .WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_d     (out_d),
        .out_mask  (out_mask),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // per-requester word queues (circular)
    logic [31:0] qd [N][QD];
    bit          ql [N][QD];
    int          hd [N];
    int          tl [N];
    bit [N-1:0]  en;

    // reference model: pair owner (-1 = none), collected words, presenting flag
    int          m_owner, m_rr, m_n, m_wait;
    bit          m_present, m_just_rst;
    logic [31:0] m_w0, m_w1;

    int          hs_cnt;
    int          hs_log [16];
    logic [31:0] hs_d0, hs_d1;
    logic [1:0]  hs_mask, hs_src;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input int i, input logic [31:0] d, input bit l);
        qd[i][tl[i]] = d;
        ql[i][tl[i]] = l;
        tl[i] = (tl[i] + 1) % QD;
    endtask

    task automatic model_reset();
        m_owner = -1; m_rr = 0; m_n = 0; m_wait = 0;
        m_present = 0; m_w0 = '0; m_w1 = '0;
        m_just_rst = 1;
    endtask

    task automatic step(input bit r, input bit ordy);
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        logic [31:0]  cd [N];
        bit           cl [N];
        int           j;
        @(negedge clk);
        rst = r;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            v[i]  = (hd[i] != tl[i]) && en[i];
            cd[i] = v[i] ? qd[i][hd[i]] : 32'h0;
            cl[i] = v[i] ? ql[i][hd[i]] : 1'b0;
            req_valid[i] = v[i];
            req_last[i]  = cl[i];
            req_data[i*32 +: 32] = cd[i];
        end
        #1;
        exp_rdy = '0;
        if (m_owner >= 0 && !m_present) exp_rdy[m_owner] = v[m_owner];
        chk("req_ready", req_ready, exp_rdy);
        chk("ready_onehot", $countones(req_ready) <= 1, 1);
        chk("out_valid", out_valid, m_present);
        if (m_present) begin
            chk("out_d0", out_d[0], m_w0);
            chk("out_d1", out_d[1], (m_n == 2) ? m_w1 : 32'h0);
            chk("out_mask", out_mask, (m_n == 2) ? 2'b11 : 2'b01);
            chk("out_src", out_src, m_owner);
        end
        if (m_just_rst) begin
            chk("rst_mask", out_mask, 0);
            chk("rst_src", out_src, 0);
            chk("rst_d0", out_d[0], 0);
            chk("rst_d1", out_d[1], 0);
        end
        if (out_valid && out_ready) begin
            if (hs_cnt < 16) hs_log[hs_cnt] = int'(out_src);
            hs_cnt++;
            hs_d0 = out_d[0]; hs_d1 = out_d[1];
            hs_mask = out_mask; hs_src = out_src;
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && v[i]) hd[i] = (hd[i] + 1) % QD;
        end
        if (r) begin
            model_reset();
        end else begin
            m_just_rst = 0;
            if (m_present) begin
                if (ordy) begin
                    m_rr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_present = 0;
                end
            end else if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (m_owner < 0 && v[j]) m_owner = j;
                end
                m_n = 0;
            end else if (v[m_owner]) begin
                if (m_n == 0) begin
                    m_w0 = cd[m_owner]; m_w1 = '0; m_n = 1; m_wait = 0;
                    if (cl[m_owner]) m_present = 1;
                end else begin
                    m_w1 = cd[m_owner]; m_n = 2; m_present = 1;
                end
            end else if (m_n == 1) begin
                m_wait++;
                if (m_wait == TMO) m_present = 1;
            end
        end
    endtask

    task automatic run_until_hs(input int max, output int used);
        int start;
        start = hs_cnt;
        used = 0;
        while (hs_cnt == start && used < max) begin
            step(0, 1);
            used++;
        end
        chk("hs_wait", hs_cnt != start, 1);
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (!out_valid && n < max) begin
            step(0, 0);
            n++;
        end
        chk("valid_wait", out_valid, 1);
    endtask

    initial begin
        int used;
        int hs0;
        int exp_seq [5];
        exp_seq = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
        rst = 1'b1; out_ready = 1'b0; en = '0;
        req_valid = '0; req_last = '0; req_data = '0;
        hs_cnt = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // reset held with every requester asking; then continuous rr service
        for (int i = 0; i < N; i++) begin
            push(i, 32'hC000_0001 + (i << 8), 1'b0);
            push(i, 32'hC000_0002 + (i << 8), 1'b1);
        end
        push(0, 32'hC000_0003, 1'b0);
        push(0, 32'hC000_0004, 1'b0);
        en = '1;
        repeat (3) step(1, 1);
        hs_cnt = 0;
        for (int p = 0; p < 5; p++) run_until_hs(40, used);
        for (int p = 0; p < 5; p++) chk("rr_seq", hs_log[p], exp_seq[p]);

        // single requester full pair, consumer stalls 5 cycles
        push(2, 32'hA5A5_0001, 1'b0);
        push(2, 32'hA5A5_0002, 1'b1);
        wait_valid(20);
        repeat (5) step(0, 0);
        hs0 = hs_cnt;
        step(0, 1);
        chk("t2_hs", hs_cnt, hs0 + 1);
        chk("t2_d0", hs_d0, 32'hA5A5_0001);
        chk("t2_d1", hs_d1, 32'hA5A5_0002);
        chk("t2_mask", hs_mask, 2'b11);
        chk("t2_src", hs_src, 2);

        // last on first word, then timeout-driven partial
        push(1, 32'h0000_1234, 1'b1);
        run_until_hs(30, used);
        chk("t4_mask", hs_mask, 2'b01);
        chk("t4_d0", hs_d0, 32'h1234);
        chk("t4_d1", hs_d1, 0);
        chk("t4_src", hs_src, 1);
        push(1, 32'h0000_5678, 1'b0);
        run_until_hs(40, used);
        chk("tmo_lat", used, TMO + 3);
        chk("tmo_mask", hs_mask, 2'b01);
        chk("tmo_d0", hs_d0, 32'h5678);
        chk("tmo_d1", hs_d1, 0);

        // reset while collecting lane1 and while presenting
        push(3, 32'hDEAD_0001, 1'b0);
        repeat (3) step(0, 1);
        step(1, 1);
        push(2, 32'hBEEF_0001, 1'b0);
        push(2, 32'hBEEF_0002, 1'b0);
        wait_valid(20);
        hs0 = hs_cnt;
        step(1, 0);
        step(0, 1);
        chk("t5_no_hs", hs_cnt, hs0);
        for (int i = 0; i < N; i++) begin
            push(i, 32'h5500_0000 + i, 1'b0);
            push(i, 32'h5500_0100 + i, 1'b0);
        end
        run_until_hs(40, used);
        chk("t5_src", hs_src, 0);

        // random traffic with valid dropouts and consumer backpressure
        for (int c = 0; c < 1500; c++) begin
            int i;
            i = $urandom_range(N - 1);
            if ($urandom_range(4) == 0 && ((tl[i] - hd[i] + QD) % QD) < QD - 2)
                push(i, $urandom, $urandom_range(3) == 0);
            for (int r = 0; r < N; r++) en[r] = ($urandom_range(3) != 0);
            step(0, $urandom_range(2) != 0);
        end
        en = '1;
        repeat (800) step(0, 1);
        for (int i = 0; i < N; i++) chk("drain_empty", hd[i], tl[i]);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
